mod_cnt_div_chk: RTL and testbench

Parametrised wrap-around counter with two independent divisibility-check channels, an up/down mode, enable and synchronous load. It is the general counter-plus-checker block for test and stimulus designs, replacing the fixed 16-bit, modulo-301, divide-by-3 arrangement. Divisibility is tracked incrementally with per-channel residue registers, so there is no wide `%` operator in the count path. The divider only appears on the load path, where the divisor is a constant.

---
 rtl/mod_cnt_div_chk.sv | 124 ++++++++++++
 tb/tb_mod_cnt_div_chk.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mod_cnt_div_chk.sv
// Wrap-around 0..MAX counter (up/down, enable, load) with two residue-tracked divisibility channels.
// Latency 1 cycle from en/ld to cnt/hit_*; no backpressure. Optional wrap event counter under MOD_CNT_WRAP_CNT_EN.
module mod_cnt_div_chk #(
    parameter int WIDTH = 16,
    parameter int MAX   = 300,
    parameter int DIV_A = 3,
    parameter int DIV_B = 5
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_hit_a,
    output logic             o_hit_b,
    output logic             o_hit_ab,
    output logic [7:0]       o_wrap_cnt
);

    localparam int RA_W = $clog2(DIV_A);
    localparam int RB_W = $clog2(DIV_B);
    localparam logic [WIDTH-1:0] C_MAX    = WIDTH'(MAX);
    localparam logic [RA_W-1:0]  C_MAX_RA = RA_W'(MAX % DIV_A);
    localparam logic [RB_W-1:0]  C_MAX_RB = RB_W'(MAX % DIV_B);
    localparam logic [RA_W-1:0]  C_TOP_RA = RA_W'(DIV_A - 1);
    localparam logic [RB_W-1:0]  C_TOP_RB = RB_W'(DIV_B - 1);

    logic [WIDTH-1:0] r_cnt;
    logic [RA_W-1:0]  r_res_a;
    logic [RB_W-1:0]  r_res_b;
    logic             r_wrap;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic [RA_W-1:0]  w_res_a_nxt;
    logic [RB_W-1:0]  w_res_b_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_ld_clamp;
    logic [31:0]      w_ld_ext;
    logic [RA_W-1:0]  w_ld_res_a;
    logic [RB_W-1:0]  w_ld_res_b;

    // The only modulo in the block: constant divisor, load path only.
    assign w_ld_clamp = (i_ld_val > C_MAX) ? C_MAX : i_ld_val;
    assign w_ld_ext   = 32'(w_ld_clamp);
    assign w_ld_res_a = RA_W'(w_ld_ext % 32'(DIV_A));
    assign w_ld_res_b = RB_W'(w_ld_ext % 32'(DIV_B));

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_res_a_nxt = r_res_a;
        w_res_b_nxt = r_res_b;
        w_wrap_nxt  = 1'b0;
        if (i_ld) begin
            w_cnt_nxt   = w_ld_clamp;
            w_res_a_nxt = w_ld_res_a;
            w_res_b_nxt = w_ld_res_b;
        end else if (i_en) begin
            if (i_dir) begin
                if (r_cnt == C_MAX) begin
                    w_cnt_nxt   = '0;
                    w_res_a_nxt = '0;
                    w_res_b_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + WIDTH'(1);
                    w_res_a_nxt = (r_res_a == C_TOP_RA) ? '0 : r_res_a + RA_W'(1);
                    w_res_b_nxt = (r_res_b == C_TOP_RB) ? '0 : r_res_b + RB_W'(1);
                end
            end else begin
                if (r_cnt == '0) begin
                    w_cnt_nxt   = C_MAX;
                    w_res_a_nxt = C_MAX_RA;
                    w_res_b_nxt = C_MAX_RB;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - WIDTH'(1);
                    w_res_a_nxt = (r_res_a == '0) ? C_TOP_RA : r_res_a - RA_W'(1);
                    w_res_b_nxt = (r_res_b == '0) ? C_TOP_RB : r_res_b - RB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt   <= '0;
            r_res_a <= '0;
            r_res_b <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_res_a <= w_res_a_nxt;
            r_res_b <= w_res_b_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

`ifdef MOD_CNT_WRAP_CNT_EN
    logic [7:0] r_wrap_cnt;

    // Saturating; load does not clear it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wrap_cnt <= 8'd0;
        end else if (w_wrap_nxt && (r_wrap_cnt != 8'hFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
        end
    end

    assign o_wrap_cnt = r_wrap_cnt;
`else
    assign o_wrap_cnt = 8'd0;
`endif

    assign o_cnt    = r_cnt;
    assign o_wrap   = r_wrap;
    assign o_hit_a  = (r_res_a == '0);
    assign o_hit_b  = (r_res_b == '0);
    assign o_hit_ab = o_hit_a & o_hit_b;

endmodule

// File: tb/tb_mod_cnt_div_chk.sv
// Scoreboard bench for mod_cnt_div_chk: default instance for function, small MAX=3 instance for wrap_cnt saturation.
module tb_mod_cnt_div_chk;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en, dir, ld;
    logic [15:0] ld_val;
    logic [15:0] cnt;
    logic        wrap, hit_a, hit_b, hit_ab;
    logic [7:0]  wrap_cnt;

    logic        s_en;
    logic [3:0]  s_cnt;
    logic        s_wrap, s_hit_a, s_hit_b, s_hit_ab;
    logic [7:0]  s_wrap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int cnt;
        int wrap;
        int ha;
        int hb;
        int hab;
        int wc;
    } exp_t;
    exp_t sb_q[$];

    int m_cnt, m_wrap, m_wc;
    int sm_cnt, sm_wc;

    always #5 clk = ~clk;

    mod_cnt_div_chk dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_dir(dir), .i_ld(ld), .i_ld_val(ld_val),
        .o_cnt(cnt), .o_wrap(wrap), .o_hit_a(hit_a), .o_hit_b(hit_b), .o_hit_ab(hit_ab),
        .o_wrap_cnt(wrap_cnt)
    );

    mod_cnt_div_chk #(.WIDTH(4), .MAX(3), .DIV_A(3), .DIV_B(2)) dut_s (
        .i_clk(clk), .i_rstn(rstn), .i_en(s_en), .i_dir(1'b1), .i_ld(1'b0), .i_ld_val(4'd0),
        .o_cnt(s_cnt), .o_wrap(s_wrap), .o_hit_a(s_hit_a), .o_hit_b(s_hit_b), .o_hit_ab(s_hit_ab),
        .o_wrap_cnt(s_wrap_cnt)
    );

    task automatic chk_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wc_inc(input int wc, input int w);
`ifdef MOD_CNT_WRAP_CNT_EN
        return (w != 0 && wc < 255) ? wc + 1 : wc;
`else
        return 0;
`endif
    endfunction

    task automatic model_step(input logic e, input logic d, input logic l, input int v);
        m_wrap = 0;
        if (l) begin
            m_cnt = (v > 300) ? 300 : v;
        end else if (e) begin
            if (d) begin
                if (m_cnt == 300) begin m_cnt = 0; m_wrap = 1; end
                else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin m_cnt = 300; m_wrap = 1; end
                else m_cnt = m_cnt - 1;
            end
        end
        m_wc = wc_inc(m_wc, m_wrap);
    endtask

    task automatic drive(input logic e, input logic d, input logic l, input int v);
        exp_t x;
        en = e; dir = d; ld = l; ld_val = 16'(v);
        model_step(e, d, l, v);
        x.cnt = m_cnt; x.wrap = m_wrap;
        x.ha = (m_cnt % 3 == 0) ? 1 : 0;
        x.hb = (m_cnt % 5 == 0) ? 1 : 0;
        x.hab = x.ha & x.hb;
        x.wc = m_wc;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        chk_val("cnt", int'(cnt), x.cnt);
        chk_val("wrap", int'(wrap), x.wrap);
        chk_val("hit_a", int'(hit_a), x.ha);
        chk_val("hit_b", int'(hit_b), x.hb);
        chk_val("hit_ab", int'(hit_ab), x.hab);
        chk_val("wrap_cnt", int'(wrap_cnt), x.wc);
    endtask

    task automatic reset_pulse(input string tag);
        rstn = 1'b0;
        #1;
        m_cnt = 0; m_wrap = 0; m_wc = 0;
        chk_val({tag, "_cnt"}, int'(cnt), 0);
        chk_val({tag, "_wrap"}, int'(wrap), 0);
        chk_val({tag, "_hit_a"}, int'(hit_a), 1);
        chk_val({tag, "_hit_b"}, int'(hit_b), 1);
        chk_val({tag, "_hit_ab"}, int'(hit_ab), 1);
        chk_val({tag, "_wrap_cnt"}, int'(wrap_cnt), 0);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; dir = 1'b1; ld = 1'b0; ld_val = 16'd0; s_en = 1'b0;
        m_cnt = 0; m_wrap = 0; m_wc = 0;
        #12;
        reset_pulse("rst");

        // Full up cycle: 0..300 then wrap to 0, one step past.
        for (int i = 0; i < 302; i++) drive(1'b1, 1'b1, 1'b0, 0);

        reset_pulse("rst2");
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 0);

        drive(1'b0, 1'b1, 1'b1, 7);
        drive(1'b1, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1000);
        drive(1'b0, 1'b1, 1'b1, 301);
        drive(1'b0, 1'b1, 1'b1, 300);
        drive(1'b1, 1'b1, 1'b1, 45);
        drive(1'b0, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b1, 1'b1, 1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 0);

        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), int'($urandom_range(0, 400)));

        drive(1'b0, 1'b1, 1'b1, 120);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 0);
        chk_val("pre_rst_cnt", int'(cnt), 123);
        #2;
        reset_pulse("rst_mid");
        drive(1'b1, 1'b1, 1'b0, 0);

        // Saturation on the small instance; main instance holds.
        en = 1'b0; ld = 1'b0;
        sm_cnt = 0; sm_wc = 0;
        s_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (sm_cnt == 3) begin sm_cnt = 0; sm_wc = wc_inc(sm_wc, 1); end
            else sm_cnt = sm_cnt + 1;
            chk_val("s_cnt", int'(s_cnt), sm_cnt);
            chk_val("s_wrap_cnt", int'(s_wrap_cnt), sm_wc);
        end
        chk_val("s_hit_a", int'(s_hit_a), (sm_cnt % 3 == 0) ? 1 : 0);
        chk_val("s_hit_b", int'(s_hit_b), (sm_cnt % 2 == 0) ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
